// File: rtl/bnn_pkg.sv
// Shared defaults, derived widths and FSM encoding for the binary conv engine.
package bnn_pkg;

  localparam int unsigned IN_CH  = 8;
  localparam int unsigned K      = 3;
  localparam int unsigned OUT_CH = 16;
  localparam int unsigned LANES  = 4;

  localparam int unsigned W  = IN_CH * K * K;
  localparam int unsigned TW = $clog2(W + 1);
  localparam int unsigned AW = ($clog2(OUT_CH) > 0) ? $clog2(OUT_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bnn_xnor_pop.sv
// One output-channel evaluator: XNOR window against weights, popcount, compare to threshold.
module bnn_xnor_pop #(
  parameter int unsigned W  = 72,
  parameter int unsigned TW = 7
) (
  input  logic [W-1:0]  window_i,
  input  logic [W-1:0]  weight_i,
  input  logic [TW-1:0] thr_i,
  output logic          hit_o
);

  logic [W-1:0]  xn;
  logic [TW-1:0] match;

  assign xn = ~(window_i ^ weight_i);

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < W; i++) begin
      match = match + TW'(xn[i]);
    end
  end

  assign hit_o = (match >= thr_i);

endmodule

// File: rtl/bnn_conv_calc.sv
// XNOR-popcount conv engine: one window in, OUT_CH binary outputs, LANES channels per cycle.
module bnn_conv_calc #(
  parameter  int unsigned IN_CH  = bnn_pkg::IN_CH,
  parameter  int unsigned K      = bnn_pkg::K,
  parameter  int unsigned OUT_CH = bnn_pkg::OUT_CH,
  parameter  int unsigned LANES  = bnn_pkg::LANES,
  localparam int unsigned W      = IN_CH * K * K,
  localparam int unsigned TW     = $clog2(W + 1),
  localparam int unsigned AW     = ($clog2(OUT_CH) > 0) ? $clog2(OUT_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      pixel_windows,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_CH-1:0] conv_out,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [W-1:0]      cfg_wdata,
  input  logic [TW-1:0]     cfg_thr,
  output logic              cfg_err
);

  import bnn_pkg::*;

  localparam int unsigned GROUPS = OUT_CH / LANES;
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if ((OUT_CH % LANES) != 0) begin : g_bad_lanes
    $error("bnn_conv_calc: OUT_CH must be a multiple of LANES");
  end

  state_e              state_q, state_d;
  logic [GW-1:0]       grp_q, grp_d;
  logic [W-1:0]        win_q;
  logic [OUT_CH-1:0]   res_q, res_d;
  logic                out_valid_q;
  logic                cfg_err_q;
  logic [W-1:0]        wgt_q [OUT_CH];
  logic [TW-1:0]       thr_q [OUT_CH];

  // Write that arrived together with an accept; held until that window's compute is over.
  logic                pend_q;
  logic [AW-1:0]       pend_addr_q;
  logic [W-1:0]        pend_wgt_q;
  logic [TW-1:0]       pend_thr_q;

  logic                accept;
  logic                last_grp;
  logic                addr_ok;
  logic                cfg_ok;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [W-1:0]        wr_wgt;
  logic [TW-1:0]       wr_thr;
  logic [LANES-1:0]    hit;
  logic [AW-1:0]       lane_ch [LANES];

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign last_grp = (grp_q == GW'(GROUPS - 1));

  if (OUT_CH == (32'(1) << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (cfg_addr < AW'(OUT_CH));
  end

  assign cfg_ok = cfg_we & addr_ok & (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          grp_d   = '0;
        end
      end
      CALC: begin
        grp_d = grp_q + GW'(1);
        if (last_grp) begin
          state_d = DONE;
          grp_d   = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = in_valid ? CALC : IDLE;
          grp_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grp_d   = '0;
      end
    endcase
  end

  // Each lane evaluates channel grp*LANES + lane against the captured window.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_ch[l] = AW'(grp_q) * AW'(LANES) + AW'(l);

    bnn_xnor_pop #(
      .W  (W),
      .TW (TW)
    ) u_pop (
      .window_i (win_q),
      .weight_i (wgt_q[lane_ch[l]]),
      .thr_i    (thr_q[lane_ch[l]]),
      .hit_o    (hit[l])
    );
  end

  always_comb begin
    res_d = res_q;
    if (state_q == CALC) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        res_d[lane_ch[l]] = hit[l];
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cfg_addr;
    wr_wgt  = cfg_wdata;
    wr_thr  = cfg_thr;
    if (pend_q && (state_q == DONE)) begin
      wr_en   = 1'b1;
      wr_addr = pend_addr_q;
      wr_wgt  = pend_wgt_q;
      wr_thr  = pend_thr_q;
    end else if (cfg_ok && !accept) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_wgt_q  <= '0;
      pend_thr_q  <= '0;
    end else begin
      if (accept) begin
        win_q <= pixel_windows;
      end
      res_q       <= res_d;
      out_valid_q <= (state_d == DONE);
      cfg_err_q   <= cfg_we & ~cfg_ok;
      if (cfg_ok && accept) begin
        pend_q      <= 1'b1;
        pend_addr_q <= cfg_addr;
        pend_wgt_q  <= cfg_wdata;
        pend_thr_q  <= cfg_thr;
      end else if (state_q == DONE) begin
        pend_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_CH; i++) begin
        wgt_q[i] <= '0;
        thr_q[i] <= '0;
      end
    end else if (wr_en) begin
      wgt_q[wr_addr] <= wr_wgt;
      thr_q[wr_addr] <= wr_thr;
    end
  end

  assign out_valid = out_valid_q;
  assign conv_out  = res_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_bnn_conv_calc.sv
// Randomised self-checking bench for bnn_conv_calc against a popcount reference model.
module tb_bnn_conv_calc;
  import bnn_pkg::*;

  localparam int unsigned OC2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, cfg_we, cfg_err;
  logic [W-1:0]      pixel_windows, cfg_wdata;
  logic [OUT_CH-1:0] conv_out;
  logic [AW-1:0]     cfg_addr;
  logic [TW-1:0]     cfg_thr;

  logic              in_valid2, in_ready2, out_valid2, out_ready2, cfg_we2, cfg_err2;
  logic [W-1:0]      pixel_windows2, cfg_wdata2;
  logic [OC2-1:0]    conv_out2;
  logic [3:0]        cfg_addr2;
  logic [TW-1:0]     cfg_thr2;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  m_wgt [OUT_CH];
  logic [TW-1:0] m_thr [OUT_CH];

  bnn_conv_calc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_windows(pixel_windows), .out_valid(out_valid), .out_ready(out_ready),
    .conv_out(conv_out), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_thr(cfg_thr), .cfg_err(cfg_err)
  );

  bnn_conv_calc #(.IN_CH(8), .K(3), .OUT_CH(OC2), .LANES(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .pixel_windows(pixel_windows2), .out_valid(out_valid2), .out_ready(out_ready2),
    .conv_out(conv_out2), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2),
    .cfg_wdata(cfg_wdata2), .cfg_thr(cfg_thr2), .cfg_err(cfg_err2)
  );

  function automatic logic [W-1:0] rnd_win();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  function automatic logic [OUT_CH-1:0] ref_conv(input logic [W-1:0] win);
    logic [OUT_CH-1:0] r;
    for (int o = 0; o < int'(OUT_CH); o++) begin
      r[o] = ($countones(~(win ^ m_wgt[o])) >= int'(m_thr[o]));
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int o = 0; o < int'(OUT_CH); o++) begin
      m_wgt[o] = '0;
      m_thr[o] = '0;
    end
  endtask

  // Entered #1 after an edge with the engine idle; returns result and accept-to-valid edges.
  task automatic send_window(input logic [W-1:0] win, output logic [OUT_CH-1:0] res,
                             output int lat);
    in_valid = 1'b1; pixel_windows = win; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; pixel_windows = rnd_win();
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = conv_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_cfg(input int addr, input logic [W-1:0] wd, input logic [TW-1:0] th,
                        output logic err);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = wd; cfg_thr = th;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    err = cfg_err;
    m_wgt[addr] = wd;
    m_thr[addr] = th;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (conv_out !== '0) begin bad++; $display("FAIL rst_conv_out: got %h want 0", conv_out); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
    total++; if (out_valid2 !== 1'b0) begin bad++; $display("FAIL rst_out_valid2: got %b want 0", out_valid2); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_no_config();
    logic [OUT_CH-1:0] res;
    int lat;
    send_window('1, res, lat);
    total++; if (res !== 16'hFFFF) begin bad++; $display("FAIL noconf_res: got %h want ffff", res); end
    total++; if (lat != 4) begin bad++; $display("FAIL noconf_latency: got %0d want 4", lat); end
  endtask

  task automatic test_full_thr();
    logic [OUT_CH-1:0] res;
    logic [W-1:0] win;
    logic err;
    int lat;
    int nerr = 0;
    for (int o = 0; o < int'(OUT_CH); o++) begin
      do_cfg(o, '1, TW'(W), err);
      if (err) nerr++;
    end
    total++; if (nerr != 0) begin bad++; $display("FAIL fullthr_cfg_err: got %0d pulses want 0", nerr); end
    send_window('1, res, lat);
    total++; if (res !== 16'hFFFF) begin bad++; $display("FAIL fullthr_ones: got %h want ffff", res); end
    win = '1; win[0] = 1'b0;
    send_window(win, res, lat);
    total++; if (res !== 16'h0000) begin bad++; $display("FAIL fullthr_bit0: got %h want 0000", res); end
    total++; if (lat != 4) begin bad++; $display("FAIL fullthr_latency: got %0d want 4", lat); end
  endtask

  task automatic test_graded();
    logic [OUT_CH-1:0] res;
    logic [W-1:0] win;
    logic err;
    int lat;
    for (int o = 0; o < int'(OUT_CH); o++) do_cfg(o, '0, TW'(5 * o), err);
    win = 72'hFF_FFFF_FFF0_0000_0000;
    send_window(win, res, lat);
    total++; if (res !== 16'h00FF) begin bad++; $display("FAIL graded_36: got %h want 00ff", res); end
    win = rnd_win();
    send_window(win, res, lat);
    total++; if (res !== ref_conv(win)) begin bad++; $display("FAIL graded_rand: got %h want %h", res, ref_conv(win)); end
  endtask

  task automatic test_random();
    logic [OUT_CH-1:0] res, exp_r;
    logic [W-1:0] win;
    logic err;
    int lat, a;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        for (int n = 0; n < int'($urandom_range(3, 1)); n++) begin
          a = int'($urandom_range(OUT_CH - 1, 0));
          do_cfg(a, rnd_win(), TW'($urandom_range(44, 28)), err);
          total++; if (err !== 1'b0) begin bad++; $display("FAIL rand_cfg_err it%0d: got %b want 0", it, err); end
        end
      end
      win = ($urandom_range(3, 0) == 0) ? ~m_wgt[$urandom_range(OUT_CH - 1, 0)] ^ W'($urandom_range(255, 0)) : rnd_win();
      exp_r = ref_conv(win);
      send_window(win, res, lat);
      total++; if (res !== exp_r) begin bad++; $display("FAIL rand_res it%0d: got %h want %h", it, res, exp_r); end
      total++; if (lat != 4) begin bad++; $display("FAIL rand_latency it%0d: got %0d want 4", it, lat); end
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] wa, wb;
    logic [OUT_CH-1:0] ea, eb;
    int lat;
    int nbad = 0;
    wa = rnd_win(); wb = rnd_win();
    ea = ref_conv(wa); eb = ref_conv(wb);
    in_valid = 1'b1; pixel_windows = wa; out_ready = 1'b0;
    @(posedge clk); #1;
    pixel_windows = wb;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL bp_latency_a: got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || conv_out !== ea) begin
        nbad++;
        $display("FAIL bp_hold cyc%0d: got ov=%b ir=%b out=%h want ov=1 ir=0 out=%h",
                 i, out_valid, in_ready, conv_out, ea);
      end
      @(posedge clk); #1;
    end
    total++; if (nbad != 0) begin bad++; $display("FAIL bp_hold_summary: got %0d bad cycles want 0", nbad); end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; pixel_windows = rnd_win();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL bp_latency_b: got %0d want 4", lat); end
    total++; if (conv_out !== eb) begin bad++; $display("FAIL bp_res_b: got %h want %h", conv_out, eb); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [OUT_CH-1:0] exp_q[$];
    logic [OUT_CH-1:0] e;
    logic [W-1:0] cur;
    logic acc;
    int n_acc = 0, n_out = 0, cyc = 0, last_acc = -1;
    cur = rnd_win();
    in_valid = 1'b1; pixel_windows = cur; out_ready = 1'b1;
    while (n_out < 6 && cyc < 100) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_unexpected: got %h want no output", conv_out);
        end else begin
          e = exp_q.pop_front();
          total++; if (conv_out !== e) begin bad++; $display("FAIL b2b_res%0d: got %h want %h", n_out, conv_out, e); end
        end
        n_out++;
      end
      acc = in_valid & in_ready;
      if (acc) begin
        exp_q.push_back(ref_conv(cur));
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc != 5) begin bad++; $display("FAIL b2b_interval: got %0d want 5", cyc - last_acc); end
        end
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk); cyc++; #1;
      if (acc) begin
        cur = rnd_win();
        pixel_windows = cur;
        in_valid = (n_acc < 6);
      end
    end
    total++; if (n_out != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", n_out); end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_gating();
    logic [W-1:0] win;
    logic [OUT_CH-1:0] res, e_old;
    logic err;
    int lat;
    win = rnd_win();
    do_cfg(3, ~win, TW'(1), err);
    e_old = ref_conv(win);
    in_valid = 1'b1; pixel_windows = win; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = AW'(3); cfg_wdata = win; cfg_thr = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL gate_calc_err: got %b want 1", cfg_err); end
    @(posedge clk); #1;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL gate_calc_pulse: got %b want 0", cfg_err); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (conv_out !== e_old) begin bad++; $display("FAIL gate_calc_res: got %h want %h", conv_out, e_old); end
    cfg_we = 1'b1; cfg_addr = AW'(3); cfg_wdata = win; cfg_thr = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL gate_done_err: got err=%b ov=%b want err=1 ov=1", cfg_err, out_valid); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    send_window(win, res, lat);
    total++; if (res !== e_old) begin bad++; $display("FAIL gate_next_res: got %h want %h", res, e_old); end
    in_valid = 1'b1; pixel_windows = win;
    cfg_we = 1'b1; cfg_addr = AW'(3); cfg_wdata = win; cfg_thr = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    m_wgt[3] = win; m_thr[3] = '0;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL gate_simul_err: got %b want 0", cfg_err); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (conv_out !== e_old) begin bad++; $display("FAIL gate_simul_old: got %h want %h", conv_out, e_old); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    send_window(win, res, lat);
    total++; if (res !== ref_conv(win)) begin bad++; $display("FAIL gate_simul_new: got %h want %h", res, ref_conv(win)); end
  endtask

  task automatic test_addr_range();
    int lat;
    cfg_we2 = 1'b1; cfg_addr2 = 4'd13; cfg_wdata2 = '0; cfg_thr2 = TW'(W);
    @(posedge clk); #1;
    cfg_we2 = 1'b0;
    total++; if (cfg_err2 !== 1'b1) begin bad++; $display("FAIL addr_oob_err: got %b want 1", cfg_err2); end
    @(posedge clk); #1;
    total++; if (cfg_err2 !== 1'b0) begin bad++; $display("FAIL addr_oob_pulse: got %b want 0", cfg_err2); end
    cfg_we2 = 1'b1; cfg_addr2 = 4'd11;
    @(posedge clk); #1;
    cfg_we2 = 1'b0;
    total++; if (cfg_err2 !== 1'b0) begin bad++; $display("FAIL addr_ok_err: got %b want 0", cfg_err2); end
    in_valid2 = 1'b1; pixel_windows2 = '1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 3) begin bad++; $display("FAIL addr_latency: got %0d want 3", lat); end
    total++; if (conv_out2 !== 12'h7FF) begin bad++; $display("FAIL addr_res: got %h want 7ff", conv_out2); end
    out_ready2 = 1'b1; @(posedge clk); #1; out_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [OUT_CH-1:0] res;
    logic err;
    int lat;
    int nbad = 0;
    for (int o = 0; o < int'(OUT_CH); o++) do_cfg(o, '0, TW'(W), err);
    in_valid = 1'b1; pixel_windows = '1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    total++; if (out_valid !== 1'b0 || conv_out !== '0) begin bad++; $display("FAIL rmid_async: got ov=%b out=%h want ov=0 out=0", out_valid, conv_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) nbad++;
      @(posedge clk); #1;
    end
    total++; if (nbad != 0) begin bad++; $display("FAIL rmid_valid: got %0d cycles with out_valid want 0", nbad); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle: got in_ready=%b want 1", in_ready); end
    send_window('1, res, lat);
    total++; if (res !== 16'hFFFF || res !== ref_conv('1)) begin bad++; $display("FAIL rmid_res: got %h want ffff", res); end
    total++; if (lat != 4) begin bad++; $display("FAIL rmid_latency: got %0d want 4", lat); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; pixel_windows = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_thr = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; pixel_windows2 = '0;
    cfg_we2 = 1'b0; cfg_addr2 = '0; cfg_wdata2 = '0; cfg_thr2 = '0;
    clear_model();
    test_reset();
    test_no_config();
    test_full_thr();
    test_graded();
    test_random();
    test_back_pressure();
    test_back_to_back();
    test_cfg_gating();
    test_addr_range();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
